cnt_calendar_date: RTL and testbench
====================================

// Module: cnt_calendar_date
// PURPOSE
//  Parametrised BCD calendar counter: day, month and year with month-length and leap-year handling.
//  Advances one day per qualified day tick from the hour counter.
//  Provides a set mode in which the user steps one selected field up or down (inc/dec).
//  Sits between the time-of-day chain and the display mux.
// PARAMETERS
//  YEAR_DIGITS   2        BCD year digits, 2 or 4. 2: year%4 leap rule. 4: full Gregorian rule.
//  RESET_DAY     8'h01    BCD day loaded on reset (must be valid for RESET_MONTH/RESET_YEAR).
//  RESET_MONTH   8'h01    BCD month loaded on reset.
//  RESET_YEAR    16'h2000 BCD year loaded on reset; the low 4*YEAR_DIGITS bits are used.
// PORTS
//  CLK            in   1        system clock; all state on rising edge.
//  RESET          in   1        synchronous, active-high reset.
//  ENABLE         in   1        count enable (time base qualifier).
//  CARRY_in       in   1        day tick from hour counter (23->00 rollover).
//  SET_MODE       in   1        1 = set mode (manual edit); 0 = run mode.
//  SET_FIELD      in   2        00 day, 01 month, 10 year, 11 none.
//  INC            in   1        single-cycle step-up request (set mode only).
//  DEC            in   1        single-cycle step-down request (set mode only).
//  DAY            out  8        BCD day, 01..DAYS_IN_MONTH.
//  MONTH          out  8        BCD month, 01..12.
//  YEAR           out  4*YD     BCD year, 0..10^YEAR_DIGITS-1.
//  DAYS_IN_MONTH  out  8        BCD length of current MONTH/YEAR (combinational).
//  IS_LEAP        out  1        current YEAR is leap (combinational).
//  CARRY_out      out  1        combinational; high in the cycle a run advance wraps the year max->0.
// BEHAVIOUR
//  Reset (sync): DAY/MONTH/YEAR <= RESET_* values. Reset overrides all other inputs in that cycle.
//  All arithmetic is per-nibble BCD; no nibble ever holds A-F.
//  Leap rule, YD=2: low year digit pair divisible by 4 (00 is leap).
//  Leap rule, YD=4: divisible by 4, except centuries; centuries divisible by 400 are leap.
//  Month lengths: 04/06/09/11 -> 30; 02 -> 29 if IS_LEAP, else 28; all others -> 31.
//  Run advance: occurs when SET_MODE=0 && ENABLE && CARRY_in; one day per cycle, latency 1 cycle.
//   - DAY < DIM: DAY+1.
//   - DAY == DIM: DAY <= 01, MONTH+1.
//   - MONTH 12 wraps to 01 with YEAR+1.
//   - YEAR at max (99 or 9999) wraps to 0, and CARRY_out=1 in that cycle.
//  Set mode (SET_MODE=1):
//   - CARRY_in is ignored and day ticks are dropped; CARRY_out stays 0.
//   - INC xor DEC steps the selected field by 1 on the next edge.
//   - INC && DEC together, or SET_FIELD=11: no change.
//   - Wraps: day DIM<->01, month 12<->01, year max<->0. No carry or borrow into other fields.
//   - Day clamp: after a month or year edit, if DAY > DIM of the new month/year, DAY <= new DIM
//     in the same edge (e.g. 2024-03-31, month DEC -> 2024-02-29).
//  Mode switch takes effect immediately. No state is lost or modified by toggling SET_MODE.
//  DAYS_IN_MONTH and IS_LEAP always reflect the registered MONTH/YEAR.
// TESTING
//  1. RESET=1 one edge, defaults, YD=4 -> DAY=01 MONTH=01 YEAR=2000, IS_LEAP=1, DIM=31, CARRY_out=0.
//  2. Feb rollover, 2024-02-28 run, 2 ticks -> 02-29 then 03-01; 2023-02-28, 1 tick -> 2023-03-01.
//  3. Century rule, YD=4: 1900-02-28 tick -> 1900-03-01; 2000-02-28 tick -> 2000-02-29.
//  4. Year wrap: 9999-12-31 (YD=4) or 99-12-31 (YD=2), tick -> 0000-01-01 / 00-01-01,
//     with CARRY_out=1 that cycle only.
//  5. Set mode:
//     - 2024-03-31, field=01, DEC -> 2024-02-29.
//     - field=00, DAY=01, DEC -> 29; INC -> 01.
//     - field=10 (YD=4), year 0000, DEC -> 9999 with no carry into month/day.
//  6. Corners:
//     - INC&DEC together -> no change.
//     - CARRY_in held high in set mode -> no change.
//     - RESET asserted with INC=1 -> reset values, no step applied.
//     - ENABLE=0 with CARRY_in=1 -> no change.

Source files
------------

// File: rtl/cnt_calendar_date.sv
// BCD calendar counter (day/month/year) with leap-year aware month lengths,
// a run mode driven by the daily tick and a set mode for stepping one field.
module cnt_calendar_date #(
  parameter int          YEAR_DIGITS = 2,
  parameter logic [7:0]  RESET_DAY   = 8'h01,
  parameter logic [7:0]  RESET_MONTH = 8'h01,
  parameter logic [15:0] RESET_YEAR  = 16'h2000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  input  logic                     CARRY_in,
  input  logic                     SET_MODE,
  input  logic [1:0]               SET_FIELD,
  input  logic                     INC,
  input  logic                     DEC,
  output logic [7:0]               DAY,
  output logic [7:0]               MONTH,
  output logic [4*YEAR_DIGITS-1:0] YEAR,
  output logic [7:0]               DAYS_IN_MONTH,
  output logic                     IS_LEAP,
  output logic                     CARRY_out
);

  localparam int             YW       = 4 * YEAR_DIGITS;
  localparam logic [YW-1:0]  YEAR_MAX = {YEAR_DIGITS{4'h9}};

  localparam logic [1:0] FIELD_DAY   = 2'b00;
  localparam logic [1:0] FIELD_MONTH = 2'b01;
  localparam logic [1:0] FIELD_YEAR  = 2'b10;

  // Two-digit BCD step helpers; callers handle the wrap points themselves.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
    if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    return {v[7:4], v[3:0] - 4'h1};
  endfunction

  // Ripple a +1 through the year digits; all-nines naturally wraps to zero.
  function automatic logic [YW-1:0] year_inc(input logic [YW-1:0] v);
    logic [YW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'h9) begin
          r[4*i +: 4] = 4'h0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'h1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [YW-1:0] year_dec(input logic [YW-1:0] v);
    logic [YW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'h0) begin
          r[4*i +: 4] = 4'h9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'h1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // 10t+u is a multiple of 4 iff 2t+u is: even tens need u in {0,4,8}, odd tens u in {2,6}.
  function automatic logic bcd2_div4(input logic [7:0] v);
    if (v[4]) return (v[3:0] == 4'h2) || (v[3:0] == 4'h6);
    return (v[3:0] == 4'h0) || (v[3:0] == 4'h4) || (v[3:0] == 4'h8);
  endfunction

  // A century (low pair 00) with 4 digits is leap only when the century pair is a multiple of 4.
  function automatic logic year_is_leap(input logic [15:0] y);
    if (YEAR_DIGITS == 4 && y[7:0] == 8'h00) return bcd2_div4(y[15:8]);
    return bcd2_div4(y[7:0]);
  endfunction

  function automatic logic [7:0] month_days(input logic [7:0] m, input logic leap);
    case (m)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  logic [7:0]    day_q, month_q;
  logic [YW-1:0] year_q;
  logic [7:0]    day_n, month_n;
  logic [YW-1:0] year_n;

  logic          leap_cur;
  logic [7:0]    dim_cur;
  logic [7:0]    dim_new;
  logic          run_adv;
  logic          set_step;

  always_comb begin
    leap_cur = year_is_leap(16'(year_q));
    dim_cur  = month_days(month_q, leap_cur);
    run_adv  = ~RESET & ~SET_MODE & ENABLE & CARRY_in;
    set_step = SET_MODE & (INC ^ DEC);
  end

  assign CARRY_out = run_adv && (day_q == dim_cur) && (month_q == 8'h12) &&
                     (year_q == YEAR_MAX);

  always_comb begin
    day_n   = day_q;
    month_n = month_q;
    year_n  = year_q;
    dim_new = dim_cur;
    if (run_adv) begin
      if (day_q != dim_cur) begin
        day_n = bcd2_inc(day_q);
      end else begin
        day_n = 8'h01;
        if (month_q == 8'h12) begin
          month_n = 8'h01;
          year_n  = year_inc(year_q);
        end else begin
          month_n = bcd2_inc(month_q);
        end
      end
    end else if (set_step) begin
      case (SET_FIELD)
        FIELD_DAY: begin
          if (INC) day_n = (day_q == dim_cur) ? 8'h01 : bcd2_inc(day_q);
          else     day_n = (day_q == 8'h01) ? dim_cur : bcd2_dec(day_q);
        end
        FIELD_MONTH: begin
          if (INC) month_n = (month_q == 8'h12) ? 8'h01 : bcd2_inc(month_q);
          else     month_n = (month_q == 8'h01) ? 8'h12 : bcd2_dec(month_q);
          dim_new = month_days(month_n, leap_cur);
          if (day_q > dim_new) day_n = dim_new;
        end
        FIELD_YEAR: begin
          year_n  = INC ? year_inc(year_q) : year_dec(year_q);
          dim_new = month_days(month_q, year_is_leap(16'(year_n)));
          if (day_q > dim_new) day_n = dim_new;
        end
        default: ;
      endcase
    end
  end

  // State registers: reset wins over every other input in the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      day_q   <= RESET_DAY;
      month_q <= RESET_MONTH;
      year_q  <= RESET_YEAR[YW-1:0];
    end else begin
      day_q   <= day_n;
      month_q <= month_n;
      year_q  <= year_n;
    end
  end

  assign DAY           = day_q;
  assign MONTH         = month_q;
  assign YEAR          = year_q;
  assign DAYS_IN_MONTH = dim_cur;
  assign IS_LEAP       = leap_cur;

endmodule

// File: tb/tb_cnt_calendar_date.sv
// Bench for cnt_calendar_date: a 4-digit and a 2-digit instance share stimulus
// and are checked against an integer calendar model.
module tb_cnt_calendar_date;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       carry_in = 1'b0;
  logic       set_mode = 1'b0;
  logic [1:0] set_field = 2'b11;
  logic       step_up = 1'b0;
  logic       step_dn = 1'b0;

  logic [7:0]  day_a, month_a, dim_a, day_b, month_b, dim_b;
  logic [15:0] year_a;
  logic [7:0]  year_b;
  logic        leap_a, leap_b, co_a, co_b;

  int vectors = 0;
  int miscompares = 0;
  logic last_co_a, last_co_b;

  // Model state: index 0 is the 4-digit instance, 1 the 2-digit one.
  int md[2], mm[2], my[2];
  int ymax[2] = '{9999, 99};
  int rd[2]   = '{1, 31};
  int rm[2]   = '{1, 12};
  int ry[2]   = '{2000, 99};

  always #5 clk = ~clk;

  cnt_calendar_date #(.YEAR_DIGITS(4)) dut_a (
    .CLK(clk), .RESET(rst), .ENABLE(enable), .CARRY_in(carry_in),
    .SET_MODE(set_mode), .SET_FIELD(set_field), .INC(step_up), .DEC(step_dn),
    .DAY(day_a), .MONTH(month_a), .YEAR(year_a), .DAYS_IN_MONTH(dim_a),
    .IS_LEAP(leap_a), .CARRY_out(co_a));

  cnt_calendar_date #(.YEAR_DIGITS(2), .RESET_DAY(8'h31), .RESET_MONTH(8'h12),
                      .RESET_YEAR(16'h0099)) dut_b (
    .CLK(clk), .RESET(rst), .ENABLE(enable), .CARRY_in(carry_in),
    .SET_MODE(set_mode), .SET_FIELD(set_field), .INC(step_up), .DEC(step_dn),
    .DAY(day_b), .MONTH(month_b), .YEAR(year_b), .DAYS_IN_MONTH(dim_b),
    .IS_LEAP(leap_b), .CARRY_out(co_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_leap(int y, int k);
    if (k == 0) return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    return (y % 4 == 0);
  endfunction

  function automatic int m_dim(int m, int y, int k);
    if (m == 2) return m_leap(y, k) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic logic [31:0] to_bcd(int v);
    return 32'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
               ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic bit m_co(int k);
    return !rst && !set_mode && enable && carry_in &&
           md[k] == m_dim(mm[k], my[k], k) && mm[k] == 12 && my[k] == ymax[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md[k] = rd[k]; mm[k] = rm[k]; my[k] = ry[k];
    end
  endtask

  task automatic model_step(input int k);
    int lim;
    if (rst) begin
      md[k] = rd[k]; mm[k] = rm[k]; my[k] = ry[k];
    end else if (!set_mode && enable && carry_in) begin
      if (md[k] < m_dim(mm[k], my[k], k)) md[k]++;
      else begin
        md[k] = 1;
        if (mm[k] < 12) mm[k]++;
        else begin
          mm[k] = 1;
          my[k] = (my[k] == ymax[k]) ? 0 : my[k] + 1;
        end
      end
    end else if (set_mode && (step_up != step_dn)) begin
      case (set_field)
        2'b00: begin
          lim = m_dim(mm[k], my[k], k);
          if (step_up) md[k] = (md[k] == lim) ? 1 : md[k] + 1;
          else         md[k] = (md[k] == 1) ? lim : md[k] - 1;
        end
        2'b01: mm[k] = step_up ? (mm[k] % 12) + 1 : ((mm[k] == 1) ? 12 : mm[k] - 1);
        2'b10: my[k] = step_up ? (my[k] + 1) % (ymax[k] + 1) : (my[k] + ymax[k]) % (ymax[k] + 1);
        default: ;
      endcase
      lim = m_dim(mm[k], my[k], k);
      if (md[k] > lim) md[k] = lim;
    end
  endtask

  task automatic cycle(input bit r, input bit sm, input bit en, input bit ci,
                       input bit up, input bit dn, input logic [1:0] fld);
    @(negedge clk);
    rst = r; set_mode = sm; enable = en; carry_in = ci;
    step_up = up; step_dn = dn; set_field = fld;
    #1;
    chk("a_carry", 32'(co_a), 32'(m_co(0)));
    chk("b_carry", 32'(co_b), 32'(m_co(1)));
    chk("a_leap", 32'(leap_a), 32'(m_leap(my[0], 0)));
    chk("b_leap", 32'(leap_b), 32'(m_leap(my[1], 1)));
    chk("a_dim", 32'(dim_a), to_bcd(m_dim(mm[0], my[0], 0)));
    chk("b_dim", 32'(dim_b), to_bcd(m_dim(mm[1], my[1], 1)));
    last_co_a = co_a;
    last_co_b = co_b;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk("a_day", 32'(day_a), to_bcd(md[0]));
    chk("a_month", 32'(month_a), to_bcd(mm[0]));
    chk("a_year", 32'(year_a), to_bcd(my[0]));
    chk("b_day", 32'(day_b), to_bcd(md[1]));
    chk("b_month", 32'(month_b), to_bcd(mm[1]));
    chk("b_year", 32'(year_b), to_bcd(my[1]));
  endtask

  task automatic tick();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
  endtask

  task automatic steps(input logic [1:0] fld, input bit up, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, up, !up, fld);
  endtask

  task automatic date_a(input string tag, input logic [15:0] y, input logic [7:0] m,
                        input logic [7:0] d);
    chk({tag, "_year"}, 32'(year_a), 32'(y));
    chk({tag, "_month"}, 32'(month_a), 32'(m));
    chk({tag, "_day"}, 32'(day_a), 32'(d));
  endtask

  initial begin
    logic [31:0] rnd;
    rst = 1'b1;
    step_up = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    date_a("reset", 16'h2000, 8'h01, 8'h01);
    chk("reset_leap", 32'(leap_a), 32'h1);
    chk("reset_dim", 32'(dim_a), 32'h31);
    chk("reset_carry", 32'(co_a), 32'h0);
    chk("reset_b_day", 32'(day_b), 32'h31);

    // 2-digit instance wraps 99-12-31 on the first tick.
    tick();
    chk("b_wrap_carry", 32'(last_co_b), 32'h1);
    chk("b_wrap_year", 32'(year_b), 32'h00);
    chk("b_wrap_day", 32'(day_b), 32'h01);
    tick();
    chk("b_carry_once", 32'(last_co_b), 32'h0);

    // Reach 2024-02-28 from 2000-01-03 by stepping fields.
    steps(2'b10, 1'b1, 24);
    steps(2'b01, 1'b1, 1);
    steps(2'b00, 1'b1, 25);
    date_a("set_2024", 16'h2024, 8'h02, 8'h28);
    tick();
    date_a("leap_29", 16'h2024, 8'h02, 8'h29);
    tick();
    date_a("leap_roll", 16'h2024, 8'h03, 8'h01);

    steps(2'b00, 1'b0, 1);
    steps(2'b01, 1'b0, 1);
    date_a("clamp_month", 16'h2024, 8'h02, 8'h29);
    steps(2'b00, 1'b1, 1);
    chk("day_inc_wrap", 32'(day_a), 32'h01);
    steps(2'b00, 1'b0, 1);
    chk("day_dec_wrap", 32'(day_a), 32'h29);
    steps(2'b00, 1'b1, 1);

    steps(2'b10, 1'b0, 1);
    steps(2'b00, 1'b0, 1);
    date_a("set_2023", 16'h2023, 8'h02, 8'h28);
    tick();
    date_a("nonleap_roll", 16'h2023, 8'h03, 8'h01);

    steps(2'b10, 1'b0, 123);
    steps(2'b01, 1'b0, 1);
    steps(2'b00, 1'b0, 1);
    date_a("set_1900", 16'h1900, 8'h02, 8'h28);
    chk("leap_1900", 32'(leap_a), 32'h0);
    tick();
    date_a("century_roll", 16'h1900, 8'h03, 8'h01);

    steps(2'b10, 1'b1, 100);
    steps(2'b01, 1'b0, 1);
    steps(2'b00, 1'b0, 2);
    date_a("set_2000", 16'h2000, 8'h02, 8'h28);
    tick();
    date_a("leap_2000", 16'h2000, 8'h02, 8'h29);

    steps(2'b10, 1'b0, 2000);
    chk("year_zero", 32'(year_a), 32'h0000);
    steps(2'b10, 1'b0, 1);
    date_a("year_underflow", 16'h9999, 8'h02, 8'h28);
    steps(2'b01, 1'b1, 10);
    steps(2'b00, 1'b1, 3);
    date_a("set_9999", 16'h9999, 8'h12, 8'h31);
    tick();
    chk("a_wrap_carry", 32'(last_co_a), 32'h1);
    date_a("year_wrap", 16'h0000, 8'h01, 8'h01);
    tick();
    chk("a_carry_once", 32'(last_co_a), 32'h0);

    // Corners: both steps, day ticks in set mode, enable low, reset over a step.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11);
    date_a("corners_hold", 16'h0000, 8'h01, 8'h02);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    date_a("reset_over_inc", 16'h2000, 8'h01, 8'h01);

    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom;
      cycle(rnd[7:0] == 8'h00, rnd[8] & rnd[9], rnd[10] | rnd[11], rnd[12] | rnd[13],
            rnd[14], rnd[15], rnd[17:16]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
